ecg_sample_mavg: RTL and testbench



---
 rtl/ecg_pkg.sv | 15 +
 rtl/ecg_mavg_buf.sv | 26 ++
 rtl/ecg_sample_mavg.sv | 129 ++++++++++++
 tb/tb_ecg_sample_mavg.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/ecg_pkg.sv
// Shared ECG front-end types and defaults.
package ecg_pkg;

  localparam int unsigned ADC_W                 = 12;
  localparam int unsigned MAVG_AVG_LOG2_DEFAULT = 3;

  typedef logic [ADC_W-1:0] adc_sample_t;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_READ = 2'd1,
    ST_SUM  = 2'd2
  } mavg_state_e;

endpackage

// File: rtl/ecg_mavg_buf.sv
// Moving-average tap history: simple dual-port RAM, one-cycle synchronous read.
module ecg_mavg_buf
  import ecg_pkg::*;
#(
  parameter int unsigned DATA_W = ADC_W,
  parameter int unsigned ADDR_W = MAVG_AVG_LOG2_DEFAULT
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents are intentionally not reset; unfilled taps are masked by the caller.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ecg_sample_mavg.sv
// Boxcar moving average of level-valid ADC samples onto a valid/ready stream.
// Optional round-half-up output when ECG_MAVG_ROUND_EN is defined.
module ecg_sample_mavg
  import ecg_pkg::*;
#(
  parameter int unsigned DATA_W   = ADC_W,
  parameter int unsigned AVG_LOG2 = MAVG_AVG_LOG2_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_dv,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);

  localparam int unsigned TAPS   = 1 << AVG_LOG2;
  localparam int unsigned SUM_W  = DATA_W + AVG_LOG2;
  localparam int unsigned FILL_W = AVG_LOG2 + 1;

  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_READ = ST_READ;
  localparam logic [1:0] S_SUM  = ST_SUM;

  logic [1:0]          state_q, state_d;
  logic                adc_dv_q;
  logic [DATA_W-1:0]   smp_q, smp_d;
  logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]   fill_q, fill_d, fill_inc;
  logic [SUM_W-1:0]    sum_q, sum_d, sum_next;
  logic [DATA_W-1:0]   out_data_d, rdata, oldest, result;
  logic                out_valid_d, overrun_d, buf_we, new_smp, fill_full;

  assign new_smp   = adc_dv & ~adc_dv_q;
  assign fill_full = (fill_q == FILL_W'(TAPS));
  assign fill_inc  = fill_full ? fill_q : fill_q + FILL_W'(1);
  assign oldest    = fill_full ? rdata : '0;
  assign sum_next  = sum_q + SUM_W'(smp_q) - SUM_W'(oldest);

`ifdef ECG_MAVG_ROUND_EN
  logic [SUM_W:0]  rnd_sum;
  logic [DATA_W:0] rnd_q;
  assign rnd_sum = {1'b0, sum_next} + (SUM_W+1)'(TAPS / 2);
  assign rnd_q   = (DATA_W+1)'(rnd_sum >> AVG_LOG2);
  assign result  = rnd_q[DATA_W] ? '1 : rnd_q[DATA_W-1:0];
`else
  assign result  = DATA_W'(sum_next >> AVG_LOG2);
`endif

  ecg_mavg_buf #(
    .DATA_W (DATA_W),
    .ADDR_W (AVG_LOG2)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_ptr_q),
    .wdata (smp_q),
    .raddr (wr_ptr_q),
    .rdata (rdata)
  );

  // Next-state and output logic.
  always_comb begin
    state_d     = state_q;
    smp_d       = smp_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    sum_d       = sum_q;
    out_data_d  = out_data;
    out_valid_d = out_valid & ~out_ready;
    overrun_d   = 1'b0;
    buf_we      = 1'b0;

    case (state_q)
      S_WAIT: begin
        if (new_smp) begin
          smp_d   = adc_data;
          state_d = S_READ;
        end
      end
      S_READ: begin
        overrun_d = new_smp;
        state_d   = S_SUM;
      end
      S_SUM: begin
        overrun_d = new_smp;
        sum_d     = sum_next;
        fill_d    = fill_inc;
        wr_ptr_d  = wr_ptr_q + AVG_LOG2'(1);
        buf_we    = 1'b1;
        state_d   = S_WAIT;
        if (fill_inc == FILL_W'(TAPS)) begin
          out_data_d  = result;
          out_valid_d = 1'b1;
          if (out_valid && !out_ready) overrun_d = 1'b1;
        end
      end
      default: state_d = S_WAIT;
    endcase
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_WAIT;
      adc_dv_q  <= 1'b0;
      smp_q     <= '0;
      wr_ptr_q  <= '0;
      fill_q    <= '0;
      sum_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      adc_dv_q  <= adc_dv;
      smp_q     <= smp_d;
      wr_ptr_q  <= wr_ptr_d;
      fill_q    <= fill_d;
      sum_q     <= sum_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      overrun   <= overrun_d;
    end
  end

endmodule

// File: tb/tb_ecg_sample_mavg.sv
// Scoreboard bench for ecg_sample_mavg (8 taps, 12-bit).
module tb_ecg_sample_mavg;
  import ecg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  adc_sample_t adc_data;
  logic        adc_dv;
  logic [11:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        overrun;

  int n_chk, n_pass, hs_cnt, ovr_cnt, last_out;
  int exp_q[$];
  int win_q[$];

  ecg_sample_mavg #(.DATA_W(12), .AVG_LOG2(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .adc_data  (adc_data),
    .adc_dv    (adc_dv),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_chk++;
    if (obs == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", tag, obs, exp_v);
  endtask

  function automatic int model_avg();
    int s = 0;
    foreach (win_q[i]) s += win_q[i];
`ifdef ECG_MAVG_ROUND_EN
    s = (s + 4) >> 3;
    if (s > 4095) s = 4095;
`else
    s = s >> 3;
`endif
    return s;
  endfunction

  function automatic void model_push(input int d);
    win_q.push_back(d);
    if (win_q.size() > 8) void'(win_q.pop_front());
    if (win_q.size() == 8) exp_q.push_back(model_avg());
  endfunction

  // One ADC conversion: dv high for two cycles, optional latency check.
  task automatic send(input int d, input bit lat);
    @(posedge clk); #1;
    adc_data = 12'(d);
    adc_dv   = 1'b1;
    model_push(d);
    @(posedge clk); #1;
    @(posedge clk); #1;
    adc_dv = 1'b0;
    if (lat) chk("lat_t2_low", int'(out_valid), 0);
    @(posedge clk); #1;
    if (lat) chk("lat_t3_high", int'(out_valid), 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    #1 chk("drain", exp_q.size(), 0);
  endtask

  // Output monitor: compare on each handshake, count overrun pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun) ovr_cnt++;
      if (out_valid && out_ready) begin
        hs_cnt++;
        last_out = int'(out_data);
        if (exp_q.size() == 0) chk("exp_pending", exp_q.size(), 1);
        else chk("out_data", int'(out_data), exp_q.pop_front());
      end
    end
  end

  initial begin
    int h0, o0;
    rst_n = 1'b0; adc_dv = 1'b0; adc_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;

    // Priming
    for (int i = 0; i < 7; i++) send(100, 1'b0);
    chk("prime_no_out", hs_cnt, 0);
    send(100, 1'b1);
    drain();
    chk("prime_one_out", hs_cnt, 1);
    chk("prime_value", last_out, 100);

    // Step response 0 -> 800
    for (int i = 0; i < 8; i++) send(0, 1'b0);
    for (int i = 0; i < 8; i++) send(800, 1'b0);
    drain();
    chk("step_final", last_out, 800);

    // Level dv held high
    h0 = hs_cnt;
    @(posedge clk); #1;
    adc_data = 12'h3FF; adc_dv = 1'b1;
    model_push(12'h3FF);
    repeat (5000) @(posedge clk);
    #1 adc_dv = 1'b0;
    repeat (5) @(posedge clk);
    drain();
    chk("level_one_out", hs_cnt - h0, 1);

    // Backpressure: second result overwrites the first
    out_ready = 1'b0;
    o0 = ovr_cnt;
    send(200, 1'b0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    send(300, 1'b0);
    chk("bp_overrun_pulse", ovr_cnt - o0, 1);
    chk("bp_valid_held", int'(out_valid), 1);
    h0 = hs_cnt;
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_drop", int'(out_valid), 0);
    chk("bp_one_hs", hs_cnt - h0, 1);
    drain();

    // Full scale and rounding
    for (int i = 0; i < 8; i++) send(4095, 1'b0);
    drain();
    chk("full_scale", last_out, 4095);
    for (int i = 0; i < 7; i++) send(0, 1'b0);
    send(4, 1'b0);
    drain();
`ifdef ECG_MAVG_ROUND_EN
    chk("round_small", last_out, 1);
`else
    chk("trunc_small", last_out, 0);
`endif

    // Reset mid-stream
    for (int i = 0; i < 5; i++) send(500, 1'b0);
    drain();
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_data", int'(out_data), 0);
    chk("mid_rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    win_q.delete();
    exp_q.delete();
    h0 = hs_cnt;
    for (int i = 0; i < 7; i++) send(500, 1'b0);
    chk("reprime_no_out", hs_cnt - h0, 0);
    send(500, 1'b1);
    drain();
    chk("reprime_one_out", hs_cnt - h0, 1);
    chk("reprime_value", last_out, 500);

    chk("total_overruns", ovr_cnt, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
